ofs_plat_avalon_mem_if_allowance_buf: RTL and testbench

- Sink-side absorber placed directly downstream of an Avalon-MM register pipeline that treats waitrequest as almost-full.
- Accepts up to WAIT_REQUEST_ALLOWANCE requests after asserting src_waitrequest, and buffers every request beat in a FIFO.
- Replays the buffered beats to a strict (zero-allowance) Avalon-MM sink.
- Read responses pass straight through, so a slave with no allowance can sit behind a registered pipeline.

---
 rtl/ofs_plat_avalon_mem_if_allowance_buf.sv | 118 +++++++++++
 tb/tb_ofs_plat_avalon_mem_if_allowance_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_avalon_mem_if_allowance_buf.sv
// Avalon-MM request absorber: accepts WAIT_REQUEST_ALLOWANCE beats past waitrequest,
// buffers them in a FIFO and replays to a strict zero-allowance sink.
module ofs_plat_avalon_mem_if_allowance_buf #(
  parameter int ADDR_WIDTH             = 32,
  parameter int DATA_WIDTH             = 512,
  parameter int BURST_CNT_WIDTH        = 7,
  parameter int WAIT_REQUEST_ALLOWANCE = 2,
  parameter int DEPTH                  = 8
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic [ADDR_WIDTH-1:0]         src_address,
  input  logic [BURST_CNT_WIDTH-1:0]    src_burstcount,
  input  logic [DATA_WIDTH-1:0]         src_writedata,
  input  logic [DATA_WIDTH/8-1:0]       src_byteenable,
  input  logic                          src_read,
  input  logic                          src_write,
  output logic                          src_waitrequest,
  output logic [DATA_WIDTH-1:0]         src_readdata,
  output logic                          src_readdatavalid,

  output logic [ADDR_WIDTH-1:0]         snk_address,
  output logic [BURST_CNT_WIDTH-1:0]    snk_burstcount,
  output logic [DATA_WIDTH-1:0]         snk_writedata,
  output logic [DATA_WIDTH/8-1:0]       snk_byteenable,
  output logic                          snk_read,
  output logic                          snk_write,
  input  logic                          snk_waitrequest,
  input  logic [DATA_WIDTH-1:0]         snk_readdata,
  input  logic                          snk_readdatavalid,

  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic                          err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < WAIT_REQUEST_ALLOWANCE + 2)) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= WAIT_REQUEST_ALLOWANCE+2");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      address;
    logic [BURST_CNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]      writedata;
    logic [DATA_WIDTH/8-1:0]    byteenable;
    logic                       is_write;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  entry_t             new_entry;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ_next;
  logic               push_req;
  logic               req_conflict;
  logic               full;
  logic               head_valid;
  logic               push;
  logic               pop;
  logic               overflow;

  always_comb begin
    push_req     = src_read | src_write;
    req_conflict = src_read & src_write;
    full         = (occupancy == OCC_W'(DEPTH));
    head_valid   = (occupancy != '0);
    pop          = head_valid & ~snk_waitrequest;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    push         = push_req & ~req_conflict & (~full | pop);
    overflow     = push_req & (req_conflict | (full & ~pop));
    occ_next     = occupancy + OCC_W'(push) - OCC_W'(pop);
  end

  always_comb begin
    new_entry            = '0;
    new_entry.address    = src_address;
    new_entry.burstcount = src_burstcount;
    new_entry.writedata  = src_writedata;
    new_entry.byteenable = src_byteenable;
    new_entry.is_write   = src_write;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occupancy       <= '0;
      src_waitrequest <= 1'b1;
      err_overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy       <= occ_next;
      src_waitrequest <= (occ_next >= OCC_W'(DEPTH - WAIT_REQUEST_ALLOWANCE));
      if (overflow) err_overflow <= 1'b1;
    end
  end

  assign head           = mem[rd_ptr];
  assign snk_address    = head.address;
  assign snk_burstcount = head.burstcount;
  assign snk_writedata  = head.writedata;
  assign snk_byteenable = head.byteenable;
  assign snk_read       = head_valid & ~head.is_write;
  assign snk_write      = head_valid & head.is_write;

  assign src_readdata      = snk_readdata;
  assign src_readdatavalid = snk_readdatavalid;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_if_allowance_buf.sv
// Scoreboard bench: the driver predicts accepted beats into a queue, the monitor
// checks the sink side and occupancy/waitrequest/error against that queue.
module tb_ofs_plat_avalon_mem_if_allowance_buf;

  localparam int AW    = 32;
  localparam int DW    = 512;
  localparam int BW    = 7;
  localparam int ALLOW = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [AW-1:0]   address;
    logic [BW-1:0]   burstcount;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            is_write;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   src_address = '0;
  logic [BW-1:0]   src_burstcount = '0;
  logic [DW-1:0]   src_writedata = '0;
  logic [DW/8-1:0] src_byteenable = '0;
  logic            src_read = 1'b0;
  logic            src_write = 1'b0;
  logic            src_waitrequest;
  logic [DW-1:0]   src_readdata;
  logic            src_readdatavalid;
  logic [AW-1:0]   snk_address;
  logic [BW-1:0]   snk_burstcount;
  logic [DW-1:0]   snk_writedata;
  logic [DW/8-1:0] snk_byteenable;
  logic            snk_read;
  logic            snk_write;
  logic            snk_waitrequest = 1'b1;
  logic [DW-1:0]   snk_readdata = '0;
  logic            snk_readdatavalid = 1'b0;
  logic [3:0]      occupancy;
  logic            err_overflow;

  ofs_plat_avalon_mem_if_allowance_buf #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
    .WAIT_REQUEST_ALLOWANCE(ALLOW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .src_address(src_address), .src_burstcount(src_burstcount),
    .src_writedata(src_writedata), .src_byteenable(src_byteenable),
    .src_read(src_read), .src_write(src_write), .src_waitrequest(src_waitrequest),
    .src_readdata(src_readdata), .src_readdatavalid(src_readdatavalid),
    .snk_address(snk_address), .snk_burstcount(snk_burstcount),
    .snk_writedata(snk_writedata), .snk_byteenable(snk_byteenable),
    .snk_read(snk_read), .snk_write(snk_write), .snk_waitrequest(snk_waitrequest),
    .snk_readdata(snk_readdata), .snk_readdatavalid(snk_readdatavalid),
    .occupancy(occupancy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    exp_occ = 0;
  logic  exp_wr = 1'b1;
  logic  exp_err = 1'b0;
  logic  pend_err = 1'b0;
  logic  in_rst = 1'b1;
  int    allow_used = 0;
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Advance to the next cycle; the model's view of FIFO state becomes what the DUT now holds.
  task automatic tick();
    @(posedge clk); #1;
    exp_occ = exp_q.size();
    exp_wr  = (exp_occ >= DEPTH - ALLOW);
    if (pend_err) exp_err = 1'b1;
    pend_err = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [BW-1:0] bc, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] be, input logic sw);
    beat_t b;
    logic  pops;
    src_read = rd; src_write = wr; src_address = addr; src_burstcount = bc;
    src_writedata = wd; src_byteenable = be; snk_waitrequest = sw;
    snk_readdata = rand_data(); snk_readdatavalid = 1'($urandom_range(0, 1));
    pops = !sw && (exp_occ > 0);
    if (rd || wr) begin
      if (rd && wr) pend_err = 1'b1;
      else if (exp_occ == DEPTH && !pops) pend_err = 1'b1;
      else begin
        b.address = addr; b.burstcount = bc; b.writedata = wd;
        b.byteenable = be; b.is_write = wr;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic idle(input logic sw);
    drive(1'b0, 1'b0, '0, '0, '0, '0, sw);
  endtask

  task automatic rand_beat(input logic is_wr, input logic sw);
    drive(!is_wr, is_wr, $urandom, BW'($urandom_range(1, 16)), rand_data(),
          {2{$urandom}}, sw);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_rst = 1'b1;
    src_read = 1'b0; src_write = 1'b0; snk_waitrequest = 1'b1;
    #1;
    chk("rst_async_waitreq", src_waitrequest, 1'b1);
    chk("rst_async_occ", occupancy, 0);
    chk("rst_async_snk_rd_wr", {snk_read, snk_write}, 2'b00);
    chk("rst_async_err", err_overflow, 1'b0);
    exp_q.delete(); exp_occ = 0; exp_err = 1'b0; pend_err = 1'b0; allow_used = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; exp_wr = 1'b1; in_rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      tick(); idle(1'b0);
    end
    tick(); idle(1'b0);
    chk(name, exp_q.size(), 0);
  endtask

  // Fill with sink stalled, writing while permitted plus the allowance beats.
  task automatic fill(output int n);
    n = 0; allow_used = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (src_waitrequest && allow_used >= ALLOW) begin idle(1'b1); break; end
      if (src_waitrequest) allow_used++;
      rand_beat(1'b1, 1'b1); n++;
    end
  endtask

  // Monitor: compares the sink side and status outputs on every falling edge.
  always @(negedge clk) begin
    if (in_rst) begin
      chk("rst_waitreq", src_waitrequest, 1'b1);
      chk("rst_occ", occupancy, 0);
      chk("rst_snk", {snk_read, snk_write}, 2'b00);
    end else begin
      chk("occupancy", occupancy, exp_occ);
      chk("waitrequest", src_waitrequest, exp_wr);
      chk("err_overflow", err_overflow, exp_err);
      chk("rdvalid_pass", src_readdatavalid, snk_readdatavalid);
      if (snk_readdatavalid) chk("rdata_pass", src_readdata, snk_readdata);
      if (exp_occ > 0 && exp_q.size() > 0) begin
        chk("snk_read", snk_read, !exp_q[0].is_write);
        chk("snk_write", snk_write, exp_q[0].is_write);
        chk("snk_address", snk_address, exp_q[0].address);
        chk("snk_burstcount", snk_burstcount, exp_q[0].burstcount);
        chk("snk_writedata", snk_writedata, exp_q[0].writedata);
        chk("snk_byteenable", snk_byteenable, exp_q[0].byteenable);
        if (!snk_waitrequest) void'(exp_q.pop_front());
      end else begin
        chk("snk_idle", {snk_read, snk_write}, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(posedge clk); #1;
    do_reset();
    repeat (3) begin tick(); idle(1'b0); end

    // Single read of burst 4 at 0x40
    tick(); drive(1'b1, 1'b0, 32'h40, 7'd4, '0, '1, 1'b0);
    repeat (3) begin tick(); idle(1'b0); end

    // Fill under stall, then drain
    fill(n);
    chk("fill_count", n, DEPTH);
    tick(); idle(1'b1);
    chk("fill_occ", occupancy, DEPTH);
    drain("drain_empty");

    // Full-rate stream of alternating reads and writes
    for (int i = 0; i < 100; i++) begin
      tick(); rand_beat(1'(i % 2), 1'b0);
    end
    drain("stream_empty");

    // Overflow: ninth beat while full and stalled
    fill(n);
    tick(); rand_beat(1'b1, 1'b1);
    tick(); idle(1'b1);
    chk("ovf_occ", occupancy, DEPTH);
    chk("ovf_err", err_overflow, 1'b1);
    drain("ovf_drain");

    // Read and write together
    do_reset();
    tick(); idle(1'b0);
    tick(); drive(1'b1, 1'b1, 32'h80, 7'd1, '0, '1, 1'b0);
    tick(); idle(1'b0);
    chk("conflict_err", err_overflow, 1'b1);
    tick(); idle(1'b0);

    // Reset in the middle of a burst
    do_reset();
    tick(); idle(1'b1);
    for (int i = 0; i < 3; i++) begin tick(); rand_beat(1'b1, 1'b1); end
    do_reset();

    // Randomized compliant traffic with random sink stalls
    allow_used = 0;
    for (int i = 0; i < 600; i++) begin
      logic sw;
      tick();
      sw = ($urandom_range(0, 3) == 0);
      if (!src_waitrequest) allow_used = 0;
      if ($urandom_range(0, 2) != 0 && (!src_waitrequest || allow_used < ALLOW)) begin
        if (src_waitrequest) allow_used++;
        rand_beat(1'($urandom_range(0, 1)), sw);
      end else begin
        idle(sw);
      end
    end
    drain("random_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
